// File: rtl/mod_m_checker_pkg.sv
// Shared types and helpers for the modulo-M count checker.
// Holds the two-state FSM encoding and the modulo successor function.
package mod_m_checker_pkg;

    // state   | meaning
    // IDLE    | not synchronised; waiting for first in-range sample
    // CHECK   | locked; every valid sample compared against prediction
    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_t;

    // Modulo-m successor: m-1 wraps to 0, everything else increments.
    function automatic int unsigned succ(input int unsigned x, input int unsigned m);
        return (x == m - 1) ? 32'd0 : x + 32'd1;
    endfunction

endpackage

// File: rtl/mod_m_count_checker.sv
// Modulo-M counter checker.
// Locks onto the first in-range sample of an observed counter, then predicts
// every following sample and flags mismatches in the value or the wrap tick.
// Optional feature: define MOD_M_CHECKER_WRAP_CNT_EN to add o_wrap_count,
// a 16-bit count of passing wrap samples.
module mod_m_count_checker
    import mod_m_checker_pkg::*;
#(
    parameter int M     = 12,
    parameter int N     = 4,
    parameter int ERR_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic [N-1:0]     i_count,
    input  logic             i_complete_tick,
    output logic             o_locked,
    output logic             o_error,
    output logic             o_error_sticky,
    output logic [ERR_W-1:0] o_err_count,
    output logic [N-1:0]     o_expected
`ifdef MOD_M_CHECKER_WRAP_CNT_EN
    ,
    output logic [15:0]      o_wrap_count
`endif
);

    localparam logic [N:0]       LP_M_EXT   = (N+1)'(M);
    localparam logic [N-1:0]     LP_LAST    = N'(M - 1);
    localparam logic [ERR_W-1:0] LP_ERR_MAX = '1;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_error;
    logic             r_error_sticky;
    logic [ERR_W-1:0] r_err_count;
    logic [N-1:0]     r_expected;
    logic [N-1:0]     w_next_expected;
    logic             w_fail;

    logic             w_count_in_range;
    logic             w_count_is_last;
    logic             w_mismatch;
    logic [N-1:0]     w_succ_count;
    logic [N-1:0]     w_succ_expected;

    assign w_count_in_range = ({1'b0, i_count} < LP_M_EXT);
    assign w_count_is_last  = (i_count == LP_LAST);
    assign w_mismatch       = (i_count != r_expected) ||
                              (i_complete_tick != w_count_is_last);
    assign w_succ_count     = N'(succ(32'(i_count), M));
    // Prediction always advances from the prediction itself, so a single
    // corrupted sample does not drag the checker off the true sequence.
    assign w_succ_expected  = N'(succ(32'(r_expected), M));

    // State register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    // Next-state, next-prediction and per-sample failure decode; clear wins over valid.
    always_comb begin
        w_next_state    = r_state;
        w_next_expected = r_expected;
        w_fail          = 1'b0;
        if (i_clear) begin
            w_next_state    = IDLE;
            w_next_expected = '0;
        end else if (i_valid) begin
            unique case (r_state)
                IDLE: begin
                    if (w_count_in_range) begin
                        w_next_state    = CHECK;
                        w_next_expected = w_succ_count;
                    end else begin
                        w_fail = 1'b1;
                    end
                end
                CHECK: begin
                    w_fail          = w_mismatch;
                    w_next_expected = w_succ_expected;
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

`ifdef MOD_M_CHECKER_WRAP_CNT_EN
    logic [15:0] r_wrap_count;
    logic        w_wrap_hit;
    assign w_wrap_hit = i_valid && !i_clear && (r_state == CHECK) &&
                        !w_mismatch && w_count_is_last;
`endif

    // Registered outputs: error pulse, sticky flag, saturating error count, prediction.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_error        <= 1'b0;
            r_error_sticky <= 1'b0;
            r_err_count    <= '0;
            r_expected     <= '0;
`ifdef MOD_M_CHECKER_WRAP_CNT_EN
            r_wrap_count   <= '0;
`endif
        end else if (i_clear) begin
            r_error        <= 1'b0;
            r_error_sticky <= 1'b0;
            r_err_count    <= '0;
            r_expected     <= '0;
`ifdef MOD_M_CHECKER_WRAP_CNT_EN
            r_wrap_count   <= '0;
`endif
        end else begin
            r_error    <= w_fail;
            r_expected <= w_next_expected;
            if (w_fail) begin
                r_error_sticky <= 1'b1;
                if (r_err_count != LP_ERR_MAX) r_err_count <= r_err_count + ERR_W'(1);
            end
`ifdef MOD_M_CHECKER_WRAP_CNT_EN
            if (w_wrap_hit) r_wrap_count <= r_wrap_count + 16'd1;
`endif
        end
    end

    assign o_locked       = (r_state == CHECK);
    assign o_error        = r_error;
    assign o_error_sticky = r_error_sticky;
    assign o_err_count    = r_err_count;
    assign o_expected     = r_expected;
`ifdef MOD_M_CHECKER_WRAP_CNT_EN
    assign o_wrap_count   = r_wrap_count;
`endif

endmodule

// File: tb/tb_mod_m_count_checker.sv
// Self-checking bench for mod_m_count_checker (M=12, N=4, ERR_W=8).
// Directed sequences followed by randomized samples, all compared against
// an arithmetic reference model of the checker's observable behaviour.
module tb_mod_m_count_checker;

    localparam int M     = 12;
    localparam int N     = 4;
    localparam int ERR_W = 8;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic             clk;
    logic             i_reset;
    logic             i_clear;
    logic             i_valid;
    logic [N-1:0]     i_count;
    logic             i_complete_tick;
    logic             o_locked;
    logic             o_error;
    logic             o_error_sticky;
    logic [ERR_W-1:0] o_err_count;
    logic [N-1:0]     o_expected;
`ifdef MOD_M_CHECKER_WRAP_CNT_EN
    logic [15:0]      o_wrap_count;
`endif

    int total = 0;
    int bad   = 0;

    // reference model state
    bit m_locked;
    int m_exp;
    bit m_err;
    bit m_sticky;
    int m_cnt;
    int m_wrap;

    mod_m_count_checker #(.M(M), .N(N), .ERR_W(ERR_W)) dut (
        .i_clk           (clk),
        .i_reset         (i_reset),
        .i_clear         (i_clear),
        .i_valid         (i_valid),
        .i_count         (i_count),
        .i_complete_tick (i_complete_tick),
        .o_locked        (o_locked),
        .o_error         (o_error),
        .o_error_sticky  (o_error_sticky),
        .o_err_count     (o_err_count),
        .o_expected      (o_expected)
`ifdef MOD_M_CHECKER_WRAP_CNT_EN
        ,
        .o_wrap_count    (o_wrap_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_locked"}, 32'(o_locked),       32'(m_locked));
        check({tag, "_error"},  32'(o_error),        32'(m_err));
        check({tag, "_sticky"}, 32'(o_error_sticky), 32'(m_sticky));
        check({tag, "_errcnt"}, 32'(o_err_count),    32'(m_cnt));
        check({tag, "_exp"},    32'(o_expected),     32'(m_exp));
`ifdef MOD_M_CHECKER_WRAP_CNT_EN
        check({tag, "_wrap"},   32'(o_wrap_count),   32'(m_wrap));
`endif
    endtask

    function automatic void model_zero();
        m_locked = 0; m_exp = 0; m_err = 0; m_sticky = 0; m_cnt = 0; m_wrap = 0;
    endfunction

    // Behaviour of one clock edge, written from the checker's rules.
    function automatic void model_edge(input bit v, input int c, input bit t, input bit clr);
        bit fail;
        fail = 0;
        if (clr) begin
            model_zero();
            return;
        end
        if (v) begin
            if (!m_locked) begin
                if (c < M) begin
                    m_locked = 1;
                    m_exp    = (c + 1) % M;
                end else begin
                    fail = 1;
                end
            end else begin
                fail = (c != m_exp) || (t != (c == M - 1));
                if (!fail && c == M - 1) m_wrap = (m_wrap + 1) % 65536;
                m_exp = (m_exp + 1) % M;
            end
        end
        m_err = fail;
        if (fail) begin
            m_sticky = 1;
            if (m_cnt < ERR_MAX) m_cnt = m_cnt + 1;
        end
    endfunction

    task automatic step(input bit v, input int c, input bit t, input bit clr, input string tag);
        i_valid         = v;
        i_count         = N'(c);
        i_complete_tick = t;
        i_clear         = clr;
        @(posedge clk);
        #1;
        model_edge(v, c, t, clr);
        check_all(tag);
        i_valid = 0;
        i_clear = 0;
    endtask

    // Correct sample: tick high exactly on M-1.
    task automatic good(input int c, input string tag);
        step(1, c, (c == M - 1), 0, tag);
    endtask

    task automatic async_reset(input string tag);
        i_valid = 0;
        i_clear = 0;
        @(negedge clk);
        #2;
        i_reset = 0;
        #1;
        model_zero();
        check_all(tag);
        @(negedge clk);
        i_reset = 1;
    endtask

    initial begin
        int c;
        bit t;
        bit v;
        bit clr;

        i_reset = 0; i_clear = 0; i_valid = 0; i_count = '0; i_complete_tick = 0;
        model_zero();
        #3;
        check_all("rst");
        @(negedge clk);
        i_reset = 1;

        // clean run 1..11,0,1 with tick on 11
        for (int k = 1; k <= 13; k++) good(k % M, "clean");
        check("clean_errcnt_final", 32'(o_err_count), 0);
        check("clean_locked_final", 32'(o_locked), 1);

        // one bad value in place of 10
        step(0, 0, 0, 1, "clr1");
        for (int k = 1; k <= 9; k++) good(k, "seq36");
        step(1, 1, 0, 0, "bad1");
        check("bad1_pulse", 32'(o_error), 1);
        good(11, "seq36b");
        check("bad1_pulse_gone", 32'(o_error), 0);
        good(0, "seq36c");
        check("seq36_cnt", 32'(o_err_count), 1);
        check("seq36_exp", 32'(o_expected), 1);

        // tick errors with correct values
        step(0, 0, 0, 1, "clr2");
        good(4, "tk_lock");
        step(1, 5, 1, 0, "tk_early");
        for (int k = 6; k <= 10; k++) good(k, "tk_mid");
        step(1, 11, 0, 0, "tk_miss");
        check("tk_cnt", 32'(o_err_count), 2);

        // out-of-range first sample, then resync
        step(0, 0, 0, 1, "clr3");
        step(1, 13, 0, 0, "oor13");
        check("oor13_locked", 32'(o_locked), 0);
        step(1, 12, 0, 0, "oor12");
        step(1, 3, 0, 0, "resync3");
        check("resync3_exp", 32'(o_expected), 4);

        // valid-low cycles hold state
        for (int k = 0; k < 3; k++) step(0, 7, 1, 0, "idlecyc");

        // clear beats a simultaneous sample
        step(1, 15, 1, 1, "clr_vs_valid");
        check("clr_vs_valid_locked", 32'(o_locked), 0);

        // saturation
        good(0, "sat_lock");
        for (int k = 0; k < 300; k++) step(1, 15, 0, 0, "sat");
        check("sat_hold", 32'(o_err_count), ERR_MAX);
        step(0, 0, 0, 1, "sat_clr");
        check("sat_clr_cnt", 32'(o_err_count), 0);

        // async reset mid-sequence, resume at 9, then three wraps
        for (int k = 0; k <= 6; k++) good(k, "pre_rst");
        async_reset("mid_rst");
        good(9, "post_rst");
        check("post_rst_exp", 32'(o_expected), 10);
        check("post_rst_locked", 32'(o_locked), 1);
        good(10, "wr");
        good(11, "wr");
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < M; k++) good(k, "wr");
        check("wr_errcnt", 32'(o_err_count), 0);
`ifdef MOD_M_CHECKER_WRAP_CNT_EN
        check("wrap3", 32'(o_wrap_count), 3);
`endif

        // randomized samples
        for (int k = 0; k < 600; k++) begin
            v   = ($urandom_range(0, 9) < 8);
            clr = ($urandom_range(0, 99) < 2);
            if (m_locked && $urandom_range(0, 9) < 8) c = m_exp;
            else                                      c = $urandom_range(0, 15);
            t = (c == M - 1);
            if ($urandom_range(0, 19) == 0) t = !t;
            step(v, c, t, clr, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
